// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: multi-cycle RAM / memory-mapped I/O access behind MAR/MDR,
// hosting the keyboard (KBSR/KBDR) and display (DSR/DDR) device registers.
module lc3_mem_ctrl #(
  parameter int WAIT_CYCLES = 4,
  parameter int MEM_AW      = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  input  logic        mem_en_i,
  input  logic        r_w_i,
  output logic [15:0] mem_data_o,
  output logic        ready_o,
  input  logic        kb_valid_i,
  input  logic [7:0]  kb_char_i,
  output logic        disp_valid_o,
  output logic [7:0]  disp_char_o,
  input  logic        disp_ready_i
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("lc3_mem_ctrl: WAIT_CYCLES must be in 1..15");
  end
  if (MEM_AW < 1 || MEM_AW > 16) begin : g_bad_aw
    $error("lc3_mem_ctrl: MEM_AW must be in 1..16");
  end

  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);
  localparam logic [15:0] KBSR_A   = 16'hFE00;
  localparam logic [15:0] KBDR_A   = 16'hFE02;
  localparam logic [15:0] DSR_A    = 16'hFE04;
  localparam logic [15:0] DDR_A    = 16'hFE06;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic [15:0] mem_data_q, mem_data_d;
  logic        kb_full_q, kb_full_d;
  logic [7:0]  kbdr_q, kbdr_d;
  logic        dsr_q, dsr_d;
  logic        disp_valid_q, disp_valid_d;
  logic [7:0]  disp_char_q, disp_char_d;

  logic [15:0] addr_q, wdata_q;
  logic        rw_q;
  logic [15:0] mem_q [2**MEM_AW];

  logic              latch_en, ram_we, kb_rd, ddr_wr, is_io;
  logic [MEM_AW-1:0] ram_idx;
  logic [15:0]       rd_data;

  // 0xFE00-0xFFFF is device space; everything below is RAM
  assign is_io   = (addr_q[15:9] == 7'h7F);
  assign ram_idx = addr_q[MEM_AW-1:0];

  always_comb begin
    rd_data = 16'h0000;
    if (!is_io) begin
      rd_data = mem_q[ram_idx];
    end else begin
      case (addr_q)
        KBSR_A:  rd_data = {kb_full_q, 15'b0};
        KBDR_A:  rd_data = {8'h00, kbdr_q};
        DSR_A:   rd_data = {dsr_q, 15'b0};
        DDR_A:   rd_data = {8'h00, disp_char_q};
        default: rd_data = 16'h0000;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ready_d      = 1'b0;
    mem_data_d   = mem_data_q;
    kb_full_d    = kb_full_q;
    kbdr_d       = kbdr_q;
    dsr_d        = dsr_q;
    disp_valid_d = disp_valid_q;
    disp_char_d  = disp_char_q;
    latch_en     = 1'b0;
    ram_we       = 1'b0;
    kb_rd        = 1'b0;
    ddr_wr       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_en_i) begin
          latch_en = 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          ready_d = 1'b1;
          state_d = DONE;
          if (rw_q) begin
            ram_we = !is_io;
            ddr_wr = (addr_q == DDR_A);
          end else begin
            mem_data_d = rd_data;
            kb_rd      = (addr_q == KBDR_A);
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (disp_valid_q && disp_ready_i) begin
      disp_valid_d = 1'b0;
      dsr_d        = 1'b1;
    end
    if (ddr_wr && dsr_q) begin
      disp_char_d  = wdata_q[7:0];
      disp_valid_d = 1'b1;
      dsr_d        = 1'b0;
    end

    // A new character arriving as KBDR is read is captured; the set beats the clear
    if (kb_rd) kb_full_d = 1'b0;
    if (kb_valid_i && (!kb_full_q || kb_rd)) begin
      kbdr_d    = kb_char_i;
      kb_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      ready_q      <= 1'b0;
      mem_data_q   <= 16'h0000;
      kb_full_q    <= 1'b0;
      kbdr_q       <= 8'h00;
      dsr_q        <= 1'b1;
      disp_valid_q <= 1'b0;
      disp_char_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      mem_data_q   <= mem_data_d;
      kb_full_q    <= kb_full_d;
      kbdr_q       <= kbdr_d;
      dsr_q        <= dsr_d;
      disp_valid_q <= disp_valid_d;
      disp_char_q  <= disp_char_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (latch_en) begin
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      rw_q    <= r_w_i;
    end
  end

  // Reset on the completing edge aborts the write
  always_ff @(posedge clk_i) begin
    if (ram_we && !rst_i) mem_q[ram_idx] <= wdata_q;
  end

  assign mem_data_o   = mem_data_q;
  assign ready_o      = ready_q;
  assign disp_valid_o = disp_valid_q;
  assign disp_char_o  = disp_char_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: vector table, multi-cycle corner sequences,
// and a randomized phase against a transaction-level model of the memory map.
module tb_lc3_mem_ctrl;
  localparam int WC = 4;

  logic        clk = 1'b0;
  logic        rst, mem_en, r_w, kb_valid, disp_ready;
  logic [15:0] addr, wdata, mem_data;
  logic        ready, disp_valid;
  logic [7:0]  kb_char, disp_char;

  always #5 clk = ~clk;

  lc3_mem_ctrl #(.WAIT_CYCLES(WC), .MEM_AW(16)) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .wdata_i(wdata), .mem_en_i(mem_en),
    .r_w_i(r_w), .mem_data_o(mem_data), .ready_o(ready), .kb_valid_i(kb_valid),
    .kb_char_i(kb_char), .disp_valid_o(disp_valid), .disp_char_o(disp_char),
    .disp_ready_i(disp_ready)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] w;
    logic        rw;
    logic [15:0] exp;
  } vec_t;
  vec_t vt[14];

  // transaction-level model state
  logic [15:0] m_ram [logic [15:0]];
  logic        m_kb_full, m_dsr, m_dv;
  logic [7:0]  m_kbdr, m_dc;
  logic [15:0] m_md;
  logic [15:0] pool [8];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h, want 0x%04h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic access(input logic [15:0] a, input logic [15:0] w, input logic rw,
                        output logic [15:0] rd);
    int lat;
    @(negedge clk);
    addr = a; wdata = w; r_w = rw; mem_en = 1'b1;
    @(posedge clk);
    #1;
    mem_en = 1'b0;
    addr = 16'($urandom); wdata = 16'($urandom); r_w = 1'($urandom);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat = k;
        break;
      end
    end
    rd = mem_data;
    chk("latency", 16'(lat), 16'(WC));
    if (lat != 0) begin
      @(posedge clk);
      #1;
      chk("ready_one_cycle", 16'(ready), 16'd0);
    end
  endtask

  task automatic kb_pulse(input logic [7:0] c);
    @(negedge clk);
    kb_valid = 1'b1; kb_char = c;
    @(negedge clk);
    kb_valid = 1'b0;
  endtask

  task automatic disp_pulse();
    @(negedge clk);
    disp_ready = 1'b1;
    @(negedge clk);
    disp_ready = 1'b0;
  endtask

  task automatic m_access(input logic [15:0] a, input logic [15:0] w, input logic rw);
    logic [15:0] e;
    if (!rw) begin
      if (a < 16'hFE00)       e = m_ram[a];
      else if (a == 16'hFE00) e = m_kb_full ? 16'h8000 : 16'h0000;
      else if (a == 16'hFE02) begin e = {8'h00, m_kbdr}; m_kb_full = 1'b0; end
      else if (a == 16'hFE04) e = m_dsr ? 16'h8000 : 16'h0000;
      else if (a == 16'hFE06) e = {8'h00, m_dc};
      else                    e = 16'h0000;
      m_md = e;
    end else begin
      if (a < 16'hFE00) m_ram[a] = w;
      else if (a == 16'hFE06 && m_dsr) begin
        m_dc = w[7:0]; m_dv = 1'b1; m_dsr = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd, last_rd, a, w;
    logic        rw;
    int          nrdy, last, seen, sel;

    rst = 1'b1; mem_en = 1'b0; r_w = 1'b0; addr = 16'h0; wdata = 16'h0;
    kb_valid = 1'b0; kb_char = 8'h0; disp_ready = 1'b0;

    vt[0]  = '{16'h3000, 16'h1234, 1'b1, 16'h0000};
    vt[1]  = '{16'h3000, 16'h0000, 1'b0, 16'h1234};
    vt[2]  = '{16'h0000, 16'hA5A5, 1'b1, 16'h0000};
    vt[3]  = '{16'hFDFF, 16'h5A5A, 1'b1, 16'h0000};
    vt[4]  = '{16'h0000, 16'h0000, 1'b0, 16'hA5A5};
    vt[5]  = '{16'hFDFF, 16'h0000, 1'b0, 16'h5A5A};
    vt[6]  = '{16'hFE00, 16'h0000, 1'b0, 16'h0000};
    vt[7]  = '{16'hFE04, 16'h0000, 1'b0, 16'h8000};
    vt[8]  = '{16'hFE08, 16'h0000, 1'b0, 16'h0000};
    vt[9]  = '{16'hFE00, 16'hFFFF, 1'b1, 16'h0000};
    vt[10] = '{16'hFE00, 16'h0000, 1'b0, 16'h0000};
    vt[11] = '{16'hFFFF, 16'h0000, 1'b0, 16'h0000};
    vt[12] = '{16'h3000, 16'hFFFF, 1'b1, 16'h0000};
    vt[13] = '{16'h3000, 16'h0000, 1'b0, 16'hFFFF};

    do_reset();
    #1;
    chk("rst_ready", 16'(ready), 16'd0);
    chk("rst_mem_data", mem_data, 16'h0000);
    chk("rst_disp_valid", 16'(disp_valid), 16'd0);
    chk("rst_disp_char", 16'(disp_char), 16'h0000);

    // vector table; writes must leave mem_data at the last read value
    last_rd = 16'h0000;
    for (int i = 0; i < 14; i++) begin
      access(vt[i].a, vt[i].w, vt[i].rw, rd);
      if (vt[i].rw) chk($sformatf("vec%0d_wr_hold", i), rd, last_rd);
      else begin
        chk($sformatf("vec%0d_rd", i), rd, vt[i].exp);
        last_rd = vt[i].exp;
      end
    end

    // mem_en held high with addr toggling every cycle; accepts land on even cycles
    nrdy = 0; last = -1;
    @(negedge clk);
    mem_en = 1'b1; r_w = 1'b0;
    for (int i = 0; i < 36; i++) begin
      if (i > 0) @(negedge clk);
      addr = (i % 2 == 1) ? 16'h3000 : 16'h0000;
      @(posedge clk);
      #1;
      if (ready) begin
        chk("hold_data", mem_data, 16'hA5A5);
        if (last >= 0) chk("hold_interval", 16'(i - last), 16'(WC + 2));
        last = i; nrdy++;
      end
    end
    @(negedge clk);
    mem_en = 1'b0;
    chk("hold_count", 16'(nrdy), 16'd6);

    // keyboard: second char dropped while full
    kb_pulse(8'h41);
    kb_pulse(8'h42);
    access(16'hFE00, 16'h0, 1'b0, rd); chk("kb_kbsr_full", rd, 16'h8000);
    access(16'hFE02, 16'h0, 1'b0, rd); chk("kb_kbdr", rd, 16'h0041);
    access(16'hFE00, 16'h0, 1'b0, rd); chk("kb_kbsr_empty", rd, 16'h0000);

    // display
    access(16'hFE06, 16'h0048, 1'b1, rd);
    chk("ddr_valid", 16'(disp_valid), 16'd1);
    chk("ddr_char", 16'(disp_char), 16'h0048);
    access(16'hFE04, 16'h0, 1'b0, rd); chk("dsr_busy", rd, 16'h0000);
    access(16'hFE06, 16'h0, 1'b0, rd); chk("ddr_read", rd, 16'h0048);
    access(16'hFE06, 16'h0049, 1'b1, rd);
    chk("ddr_dropped", 16'(disp_char), 16'h0048);
    disp_pulse();
    #1;
    chk("disp_consumed", 16'(disp_valid), 16'd0);
    access(16'hFE04, 16'h0, 1'b0, rd); chk("dsr_idle", rd, 16'h8000);
    access(16'hFE06, 16'h004A, 1'b1, rd);
    chk("ddr_second", 16'(disp_char), 16'h004A);

    // reset while a write is BUSY
    access(16'h4000, 16'h1357, 1'b1, rd);
    @(negedge clk);
    addr = 16'h4000; wdata = 16'hBEEF; r_w = 1'b1; mem_en = 1'b1;
    @(posedge clk);
    #1;
    mem_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_ready", 16'(ready), 16'd0);
    chk("abort_mem_data", mem_data, 16'h0000);
    chk("abort_disp_valid", 16'(disp_valid), 16'd0);
    chk("abort_disp_char", 16'(disp_char), 16'h0000);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (ready) seen++;
    end
    chk("abort_no_ready", 16'(seen), 16'd0);
    access(16'h4000, 16'h0, 1'b0, rd); chk("abort_ram_kept", rd, 16'h1357);
    access(16'hFE04, 16'h0, 1'b0, rd); chk("abort_dsr", rd, 16'h8000);

    // KBDR read completing on the same edge as a new keyboard character
    kb_pulse(8'h33);
    @(negedge clk);
    addr = 16'hFE02; r_w = 1'b0; mem_en = 1'b1;
    @(posedge clk);
    #1;
    mem_en = 1'b0;
    repeat (WC - 1) @(posedge clk);
    @(negedge clk);
    kb_valid = 1'b1; kb_char = 8'h5A;
    @(posedge clk);
    #1;
    kb_valid = 1'b0;
    chk("race_ready", 16'(ready), 16'd1);
    chk("race_old_char", mem_data, 16'h0033);
    @(posedge clk);
    #1;
    access(16'hFE00, 16'h0, 1'b0, rd); chk("race_kbsr", rd, 16'h8000);
    access(16'hFE02, 16'h0, 1'b0, rd); chk("race_kbdr", rd, 16'h005A);

    // randomized phase against the model
    do_reset();
    m_kb_full = 1'b0; m_kbdr = 8'h00; m_dsr = 1'b1; m_dv = 1'b0; m_dc = 8'h00; m_md = 16'h0;
    for (int i = 0; i < 8; i++) begin
      pool[i] = 16'($urandom_range(0, 32'hFDFF));
      w = 16'($urandom);
      access(pool[i], w, 1'b1, rd);
      m_access(pool[i], w, 1'b1);
    end
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        kb_char = 8'($urandom);
        w[7:0] = kb_char;
        kb_pulse(w[7:0]);
        if (!m_kb_full) begin m_kbdr = w[7:0]; m_kb_full = 1'b1; end
      end
      if ($urandom_range(0, 2) == 0) begin
        disp_pulse();
        if (m_dv) begin m_dv = 1'b0; m_dsr = 1'b1; end
      end
      sel = $urandom_range(0, 12);
      case (sel)
        8:       a = 16'hFE00;
        9:       a = 16'hFE02;
        10:      a = 16'hFE04;
        11:      a = 16'hFE06;
        12:      a = 16'hFFFE;
        default: a = pool[sel];
      endcase
      w  = 16'($urandom);
      rw = 1'($urandom);
      access(a, w, rw, rd);
      m_access(a, w, rw);
      chk($sformatf("rnd%0d_mem_data", i), rd, m_md);
      chk($sformatf("rnd%0d_disp_valid", i), 16'(disp_valid), 16'(m_dv));
      chk($sformatf("rnd%0d_disp_char", i), 16'(disp_char), 16'(m_dc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
